// File: rtl/tcg_rom_arbiter.sv
// Round-robin arbiter sharing one character-generator ROM between glyph prefetchers.
// Issues single-row reads or BURST_LEN-row glyph bursts; responses return two cycles after grant.
module tcg_rom_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_burst,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic {IDLE, BURST} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                tag_vld_q, tag_vld_d;
    logic                tag_last_q, tag_last_d;
    logic [PTR_W-1:0]    tag_id_q, tag_id_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;

    logic                win_vld;
    logic [PTR_W-1:0]    win;
    logic [PTR_W:0]      scan_sum;
    logic [PTR_W-1:0]    scan_idx;

    // Rotating-priority scan: first set req starting at ptr_q, wrapping at N_REQ.
    always_comb begin
        win_vld  = 1'b0;
        win      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(N_REQ))
                scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            scan_idx = scan_sum[PTR_W-1:0];
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win     = scan_idx;
            end
        end
    end

    // Reset gates the grant so nothing is offered while the block is held in reset.
    assign gnt = (rst_n && win_vld && state_q == IDLE) ? (N_REQ'(1) << win) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        count_d    = count_q;
        rom_addr_d = rom_addr_q;
        tag_vld_d  = 1'b0;
        tag_id_d   = tag_id_q;
        tag_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    rom_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    tag_vld_d  = 1'b1;
                    tag_id_d   = win;
                    tag_last_d = ~req_burst[win];
                    ptr_d      = (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
                    if (req_burst[win]) begin
                        state_d = BURST;
                        owner_d = win;
                        count_d = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                rom_addr_d = rom_addr_q + 1'b1;
                tag_vld_d  = 1'b1;
                tag_id_d   = owner_q;
                tag_last_d = (count_q == CNT_W'(BURST_LEN-1));
                count_d    = count_q + 1'b1;
                if (tag_last_d) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = tag_vld_q ? (N_REQ'(1) << tag_id_q) : '0;
        rsp_last_d  = tag_vld_q & tag_last_q;
        rsp_data_d  = tag_vld_q ? rom_data : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            count_q     <= '0;
            rom_addr_q  <= '0;
            tag_vld_q   <= 1'b0;
            tag_id_q    <= '0;
            tag_last_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            rom_addr_q  <= rom_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            tag_last_q  <= tag_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_tcg_rom_arbiter.sv
// Bench for tcg_rom_arbiter: directed and random requesters against a queue-based
// model of grant order, blocking windows and expected response rows.
module tb_tcg_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int BL = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_burst = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic            busy;

    tcg_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_burst(req_burst), .req_addr(req_addr),
        .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [15:0] t;
        t = {7'd0, a} * 16'd29 + 16'd3;
        return t[7:0] ^ {a[8:2], a[0]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    typedef struct { int due; int id; int addr; bit last; } row_t;
    row_t         q[$];
    int           vectors = 0, misc = 0, cyc = 0;
    int           ptr = 0, block = 0;
    logic [DW-1:0] last_d = '0;
    bit           pend[N], pburst[N], sticky[N];
    int           paddr[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            req_burst[i] = pburst[i];
            req_addr[i*AW +: AW] = AW'(paddr[i]);
        end
    endtask

    function automatic int ref_winner();
        if (!rst_n || block > 0) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic check_cycle(output int w);
        row_t        e;
        logic [N-1:0] ev;
        logic        el;
        w = ref_winner();
        chk("gnt", gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("busy", busy, (block > 0) ? 32'd1 : 32'd0);
        ev = '0;
        el = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = N'(1) << e.id;
            el = e.last;
            last_d = rom_fn(AW'(e.addr));
        end
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_last", rsp_last, el);
        chk("rsp_data", rsp_data, last_d);
        if (q.size() > 0 && q[0].due == cyc + 1)
            chk("rom_addr", rom_addr, q[0].addr);
        if (w >= 0) begin
            ptr = (w + 1) % N;
            if (pburst[w]) begin
                block = BL - 1;
                for (int k = 0; k < BL; k++)
                    q.push_back('{cyc + 2 + k, w, (paddr[w] + k) % (1 << AW), k == BL - 1});
            end else begin
                q.push_back('{cyc + 2, w, paddr[w], 1'b1});
            end
        end else if (block > 0) begin
            block--;
        end
    endtask

    task automatic step();
        int w;
        drive();
        @(negedge clk);
        check_cycle(w);
        @(posedge clk);
        #1;
        if (w >= 0 && !sticky[w]) pend[w] = 1'b0;
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        ptr = 0;
        block = 0;
        last_d = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            sticky[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input bit b, input int a);
        pend[i] = 1'b1;
        pburst[i] = b;
        paddr[i] = a;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_gnt", gnt, 0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        // reset held: requests toggling must not produce a grant
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16 * i);
        repeat (3) begin
            step();
            for (int i = 0; i < N; i++) pend[i] = ~pend[i];
        end
        chk("rst_hold_rom_addr", rom_addr, 0);
        model_reset();
        rst_n = 1'b1;

        // lowest set index first after reset
        set_req(1, 1'b0, 9'h033);
        set_req(3, 1'b0, 9'h0F0);
        repeat (4) step();

        // single read
        set_req(2, 1'b0, 9'h041);
        repeat (4) step();

        // round-robin with all requesting continuously
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 9'h100 + i);
            sticky[i] = 1'b1;
        end
        repeat (8) step();
        for (int i = 0; i < N; i++) begin
            sticky[i] = 1'b0;
            pend[i] = 1'b0;
        end
        repeat (3) step();

        // wrapping burst, concurrent single waits for busy to fall
        set_req(1, 1'b1, 9'h1FC);
        step();
        set_req(0, 1'b0, 9'h010);
        repeat (12) step();

        // lone requester regranted every cycle
        set_req(2, 1'b0, 9'h077);
        sticky[2] = 1'b1;
        repeat (4) step();
        sticky[2] = 1'b0;
        pend[2] = 1'b0;
        repeat (3) step();

        // reset during a burst, then a fresh full burst
        set_req(3, 1'b1, 9'h100);
        repeat (5) step();
        async_reset();
        repeat (3) step();
        set_req(3, 1'b1, 9'h100);
        repeat (11) step();

        // repeated bursts from 0 must not starve 3
        set_req(0, 1'b1, 9'h080);
        sticky[0] = 1'b1;
        step();
        set_req(3, 1'b0, 9'h1AA);
        repeat (20) step();
        sticky[0] = 1'b0;
        pend[0] = 1'b0;
        repeat (10) step();

        // random traffic with one reset partway through
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 3) == 0, int'($urandom_range(0, (1 << AW) - 1)));
                else if (pend[i] && $urandom_range(0, 15) == 0)
                    pend[i] = 1'b0;
            end
            if (c == 200) async_reset();
            step();
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule

// File: doc/tcg_rom_arbiter.md
Name: tcg_rom_arbiter

Overview:
- Shares one character-generator ROM (tcgrom, 9-bit address, 8-bit row data) between up to N_REQ character-render requesters. Each requester is a glyph prefetcher feeding a char display box.
- Round-robin arbitration, registered ROM address, registered response.
- Supports single-row reads and 8-row glyph bursts, so a whole 8x8 glyph can be cached per box during blanking.
- Sits between the per-box prefetchers and the single tcgrom instance in the score display path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 9, ROM address width.
- DATA_W, 8, ROM row width.
- BURST_LEN, 8, rows per burst (glyph height).

Ports:
- clk  input  1  pixel clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request; held high until granted.
- req_burst  input  N_REQ  qualifies req[i]: 1 = BURST_LEN-row burst, 0 = single row.
- req_addr  input  N_REQ*ADDR_W  packed start addresses; slice i = req_addr[i*ADDR_W +: ADDR_W]; held stable until granted.
- gnt  output  N_REQ  one-hot, combinational, one cycle per accepted request.
- rom_addr  output  ADDR_W  registered address to tcgrom.
- rom_data  input  DATA_W  combinational tcgrom row data for rom_addr.
- rsp_valid  output  N_REQ  one-hot, registered, marks a valid rsp_data for requester i.
- rsp_data  output  DATA_W  registered row data.
- rsp_last  output  1  high with the final rsp_valid of a transfer (single read or last burst row).
- busy  output  1  high while in BURST state.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on assertion.
- Reset values: gnt=0, rom_addr=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, priority pointer=0, state=IDLE, burst counter=0.
- Reset mid-burst or mid-pipeline: in-flight transfers are dropped, with no rsp_valid after reset release.
- Requesters re-request after reset; the arbiter does not replay lost transfers.
- FSM states: IDLE, BURST.
- IDLE, grant selection:
  - If any req is high, gnt[w] is asserted combinationally.
  - w is the first set req index scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
- IDLE, grant edge:
  - rom_addr <= req_addr slice w.
  - Pipeline tag <= {w, last}, where last = ~req_burst[w].
  - ptr <= (w+1) mod N_REQ.
  - If req_burst[w]=1: state <= BURST, owner <= w, count <= 1.
- IDLE, single reads: back-to-back single grants are allowed every cycle (throughput 1 read/cycle).
- BURST state:
  - gnt=0 for everyone and busy=1.
  - Each edge: rom_addr <= rom_addr+1, with modulo 2^ADDR_W wrap (0x1FF -> 0x000).
  - count increments each edge. The tag is marked last when count = BURST_LEN-1.
  - After the edge that issues address base+BURST_LEN-1, state <= IDLE.
  - Total issued: BURST_LEN consecutive addresses, with no gaps.
  - The first new grant is possible in the first IDLE cycle.
- Response pipeline:
  - The edge after an address is issued captures rsp_data <= rom_data, rsp_valid <= onehot(tag owner), rsp_last <= tag last.
  - Latency: gnt high in cycle G gives rsp_valid in cycle G+2. Burst row k arrives in cycle G+2+k.
- Idle output: when nothing is issued, rsp_valid=0 and rsp_last=0. rsp_data holds its last value.
- Requests during BURST: other requests wait. req held with no gnt is legal and must not be lost.
- Deassertion: a requester dropping req before gnt simply withdraws, with no side effects.
- Simultaneous events:
  - The final BURST cycle and new requests give no grant that cycle. The grant occurs the next cycle (IDLE).
  - A lone requester is regranted every cycle while req stays high.
- Fairness: with all N_REQ requesting continuously, each is granted at most once per N_REQ grants. There is no starvation.
- Arithmetic: ptr is $clog2(N_REQ) bits with explicit mod wrap for non-power-of-2 N_REQ. count is $clog2(BURST_LEN)+1 bits.

Test Plan:
- Reset: hold rst_n=0, then toggle req -> all outputs 0, no gnt. Release rst_n -> first gnt goes to the lowest set index (ptr=0).
- Single read: req[2]=1, burst=0, addr=0x041 at cycle 0 -> gnt[2] in cycle 0; rom_addr=0x041 in cycle 1; rsp_valid=0100, rsp_data=tcgrom[0x041], rsp_last=1 in cycle 2.
- Round-robin: req=1111 continuously, all single -> gnt sequence 0,1,2,3,0,1; rsp_valid order identical, delayed 2 cycles.
- Burst: req[1]=1, burst=1, addr=0x1FC -> rom_addr 0x1FC,0x1FD,0x1FE,0x1FF,0x000,0x001,0x002,0x003; rsp_valid[1] for 8 consecutive cycles; rsp_last only on the 8th; busy high 7 cycles. Concurrent req[0] is granted the cycle after busy falls.
- Async reset mid-burst: rst_n low during row 4 -> rsp_valid=0 at once, no further responses after release. Re-requesting then yields a fresh full burst.
- Starvation check: req[3] held high while req[0] issues repeated bursts -> req[3] is granted immediately after the first burst completes.
